alu_mdu: RTL and testbench
==========================

Name: alu_mdu

Overview:
- Parametrised successor to the single-cycle datapath ALU.
- Keeps the same-cycle combinational ops and adds an iterative multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage. The control unit stalls the pipeline on busy and uses mfhi/mflo/mthi/mtlo to move data.

Parameters:
- WIDTH, 32: datapath width. Must be even and ≥8.
- SHW, $clog2(WIDTH): shift-amount width.
- CTRL_W, 6: width of alu_ctrl.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_ctrl  in  CTRL_W  operation select (codes in include.v).
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt/imm).
- start  in  1  qualifies sequential ops (mult*, div*, mthi, mtlo).
- c  out  WIDTH  combinational result.
- zero  out  1  1 when a==b.
- busy  out  1  multiply/divide in progress.
- done  out  1  one-cycle pulse; hi/lo are valid with it.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: async, active-high. Forces FSM=IDLE, hi=lo=0, busy=0, done=0 and clears internal operand/accumulator registers. Reset mid-operation aborts with no hi/lo update.
- Combinational ops, result valid in the same cycle, independent of start/busy:
  - add/addu: a+b, wrap modulo 2^WIDTH, no overflow trap.
  - subu: a-b.
  - and, or, xor, nor.
  - slt: signed compare. sltu: unsigned compare. Result is 1 or 0, zero-extended.
  - lui: {b[WIDTH/2-1:0], zeros}.
  - sll/srl/sra: shift b by a[SHW-1:0].
  - mfhi: c=hi. mflo: c=lo. While busy, these return the old values; the control unit must stall.
  - Unlisted or sequential codes: c=0.
- zero: (a==b), purely combinational.
- mthi/mtlo: when start=1 and FSM in IDLE or DONE, hi (or lo) <= a at the clock edge. Ignored while busy. No done pulse.
- FSM states: IDLE, ITER, FIX, DONE.
  - IDLE/DONE + start + mult/multu/div/divu: latch operands; signed ops store magnitudes plus sign flags; counter=WIDTH; next state ITER. Divide with b==0 goes directly to FIX.
  - ITER: one bit per cycle. Multiply is shift-add into a 2*WIDTH accumulator. Divide is restoring (shift remainder, trial subtract, set quotient bit). Decrement counter; when it reaches 1 → FIX.
  - FIX: apply signs.
    - Product is negated if signs differ.
    - Quotient is negated if signs differ (truncation toward zero).
    - Remainder takes the sign of the dividend.
    - Write hi/lo at the end of this cycle → DONE.
  - DONE: done=1 for one cycle. Next state is IDLE, or ITER if a new start is accepted.
- Results:
  - Multiply: {hi,lo} = full 2*WIDTH product.
  - Divide: lo = quotient, hi = remainder.
  - Divide by zero: hi=a, lo=all ones (both signed and unsigned).
  - Signed MIN/-1: lo=MIN, hi=0. This falls out of the magnitude algorithm; no special case.
- Timing: start sampled at edge 0.
  - busy=1 for cycles 1..WIDTH+1 (WIDTH ITER cycles plus FIX).
  - done=1 in cycle WIDTH+2, with hi/lo already updated; busy=0 in that cycle.
  - Divide by zero: busy only in cycle 1, done in cycle 2.
- start while busy is ignored, including sequential ops; hi/lo are untouched. start with a combinational code has no sequential effect.
- Operands a/b may change freely after the start edge.

Decomposition:
- include.v holds the shared op-code defines:
  - Existing: add_op, addu_op, subu_op, and_op, or_op, slt_op, lui_op.
  - New: xor_op, nor_op, sltu_op, sll_op, srl_op, sra_op, mult_op, multu_op, div_op, divu_op, mfhi_op, mflo_op, mthi_op, mtlo_op.
- Sub-module mdu_core: owns the FSM, counter, accumulator, sign fix-up and hi/lo. alu_mdu keeps the combinational ops and the output mux.

Test Plan:
1. add 5+7 → c=12. slt a=0xFFFFFFFF, b=1 → c=1. sltu same operands → c=0. lui b=0x1234 → c=0x12340000. a==b → zero=1.
2. multu 0xFFFFFFFF*0xFFFFFFFF, start at edge 0 → busy cycles 1–33, done in cycle 34, hi=0xFFFFFFFE, lo=0x00000001.
3. div -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 → lo=14, hi=2.
4. div a=0x1234, b=0 → busy cycle 1 only, done cycle 2, hi=0x1234, lo=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
5. mult 3*4 then, during busy, start mthi a=0xAA → hi=0, lo=12 after done. Then mthi 0xAA → hi=0xAA. mfhi → c=0xAA.
6. Assert rst in cycle 10 of a mult → busy=0, hi=lo=0 immediately, no done pulse. A mult issued after release completes normally.

Source files
------------

// File: rtl/alu_mdu_pkg.sv
// Shared op-codes, FSM states and MDU command type for the EX-stage ALU/MDU.
package alu_mdu_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_SLL   = 6'h00;
  localparam logic [OP_W-1:0] OP_SRL   = 6'h02;
  localparam logic [OP_W-1:0] OP_SRA   = 6'h03;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_MFHI  = 6'h10;
  localparam logic [OP_W-1:0] OP_MTHI  = 6'h11;
  localparam logic [OP_W-1:0] OP_MFLO  = 6'h12;
  localparam logic [OP_W-1:0] OP_MTLO  = 6'h13;
  localparam logic [OP_W-1:0] OP_MULT  = 6'h18;
  localparam logic [OP_W-1:0] OP_MULTU = 6'h19;
  localparam logic [OP_W-1:0] OP_DIV   = 6'h1A;
  localparam logic [OP_W-1:0] OP_DIVU  = 6'h1B;
  localparam logic [OP_W-1:0] OP_ADD   = 6'h20;
  localparam logic [OP_W-1:0] OP_ADDU  = 6'h21;
  localparam logic [OP_W-1:0] OP_SUBU  = 6'h23;
  localparam logic [OP_W-1:0] OP_AND   = 6'h24;
  localparam logic [OP_W-1:0] OP_OR    = 6'h25;
  localparam logic [OP_W-1:0] OP_XOR   = 6'h26;
  localparam logic [OP_W-1:0] OP_NOR   = 6'h27;
  localparam logic [OP_W-1:0] OP_SLT   = 6'h2A;
  localparam logic [OP_W-1:0] OP_SLTU  = 6'h2B;

  typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_FIX, ST_DONE} mdu_state_e;

  typedef enum logic [2:0] {
    MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO
  } mdu_op_e;

endpackage

// File: rtl/alu_mdu_core.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, sign fix-up
// on magnitudes, and the architectural HI/LO registers.
module mdu_core
  import alu_mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  mdu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  mdu_state_e         state_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q, neg_q_q, neg_r_q, div0_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               busy_q, done_q;

  logic               can_accept_c, is_mul_c, is_div_c, is_signed_c;
  logic [WIDTH-1:0]   mag_a_c, mag_b_c;
  logic [WIDTH:0]     mul_sum_c;
  logic [2*WIDTH-1:0] mul_next_c, div_next_c, prod_c;
  logic [2*WIDTH:0]   div_sh_c;
  logic [WIDTH:0]     trial_c;
  logic [WIDTH-1:0]   quo_c, rem_c;

  always_comb begin
    can_accept_c = (state_q == ST_IDLE) || (state_q == ST_DONE);
    is_mul_c     = (op_i == MDU_MULT) || (op_i == MDU_MULTU);
    is_div_c     = (op_i == MDU_DIV)  || (op_i == MDU_DIVU);
    is_signed_c  = (op_i == MDU_MULT) || (op_i == MDU_DIV);
    mag_a_c      = (is_signed_c && a_i[WIDTH-1]) ? -a_i : a_i;
    mag_b_c      = (is_signed_c && b_i[WIDTH-1]) ? -b_i : b_i;
    // Multiply: conditional add into upper half, then shift the whole accumulator right
    mul_sum_c    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : WIDTH'(0))};
    mul_next_c   = {mul_sum_c, acc_q[WIDTH-1:1]};
    // Divide: shift {rem,quo} left, trial-subtract divisor, keep result if non-negative
    div_sh_c     = {acc_q, 1'b0};
    trial_c      = div_sh_c[2*WIDTH:WIDTH] - {1'b0, opb_q};
    div_next_c   = trial_c[WIDTH] ? div_sh_c[2*WIDTH-1:0]
                                  : {trial_c[WIDTH-1:0], div_sh_c[WIDTH-1:1], 1'b1};
    prod_c       = neg_q_q ? -acc_q : acc_q;
    quo_c        = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_c        = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          if (start_i && can_accept_c && (is_mul_c || is_div_c)) begin
            is_div_q <= is_div_c;
            neg_q_q  <= is_signed_c && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_r_q  <= is_signed_c && a_i[WIDTH-1];
            opb_q    <= mag_b_c;
            cnt_q    <= CNT_W'(WIDTH);
            busy_q   <= 1'b1;
            if (is_div_c && (b_i == '0)) begin
              // Divide by zero skips iteration; raw dividend is parked for HI
              div0_q  <= 1'b1;
              acc_q   <= {a_i, WIDTH'(0)};
              state_q <= ST_FIX;
            end else begin
              div0_q  <= 1'b0;
              acc_q   <= {WIDTH'(0), mag_a_c};
              state_q <= ST_ITER;
            end
          end else if (start_i && (op_i == MDU_MTHI)) begin
            hi_q <= a_i;
          end else if (start_i && (op_i == MDU_MTLO)) begin
            lo_q <= a_i;
          end
        end
        ST_ITER: begin
          acc_q <= is_div_q ? div_next_c : mul_next_c;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          if (div0_q) begin
            hi_q <= acc_q[2*WIDTH-1:WIDTH];
            lo_q <= '1;
          end else if (is_div_q) begin
            hi_q <= rem_c;
            lo_q <= quo_c;
          end else begin
            {hi_q, lo_q} <= prod_c;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU: same-cycle combinational ops plus the iterative MDU with HI/LO.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned SHW    = $clog2(WIDTH),
  parameter int unsigned CTRL_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              start,
  output logic [WIDTH-1:0]  c,
  output logic              zero,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  logic [WIDTH-1:0] res_c;
  logic [SHW-1:0]   shamt_c;
  mdu_op_e          mdu_op_c;

  assign shamt_c = a[SHW-1:0];

  always_comb begin
    res_c    = '0;
    mdu_op_c = MDU_NONE;
    case (alu_ctrl)
      CTRL_W'(OP_ADD), CTRL_W'(OP_ADDU): res_c = a + b;
      CTRL_W'(OP_SUBU):  res_c = a - b;
      CTRL_W'(OP_AND):   res_c = a & b;
      CTRL_W'(OP_OR):    res_c = a | b;
      CTRL_W'(OP_XOR):   res_c = a ^ b;
      CTRL_W'(OP_NOR):   res_c = ~(a | b);
      CTRL_W'(OP_SLT):   res_c = WIDTH'($signed(a) < $signed(b));
      CTRL_W'(OP_SLTU):  res_c = WIDTH'(a < b);
      CTRL_W'(OP_LUI):   res_c = {b[WIDTH/2-1:0], (WIDTH/2)'(0)};
      CTRL_W'(OP_SLL):   res_c = b << shamt_c;
      CTRL_W'(OP_SRL):   res_c = b >> shamt_c;
      CTRL_W'(OP_SRA):   res_c = $signed(b) >>> shamt_c;
      CTRL_W'(OP_MFHI):  res_c = hi;
      CTRL_W'(OP_MFLO):  res_c = lo;
      CTRL_W'(OP_MULT):  mdu_op_c = MDU_MULT;
      CTRL_W'(OP_MULTU): mdu_op_c = MDU_MULTU;
      CTRL_W'(OP_DIV):   mdu_op_c = MDU_DIV;
      CTRL_W'(OP_DIVU):  mdu_op_c = MDU_DIVU;
      CTRL_W'(OP_MTHI):  mdu_op_c = MDU_MTHI;
      CTRL_W'(OP_MTLO):  mdu_op_c = MDU_MTLO;
      default: ;
    endcase
  end

  assign c    = res_c;
  assign zero = (a == b);

  mdu_core #(.WIDTH(WIDTH)) u_mdu (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .op_i    (mdu_op_c),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed vectors, HI/LO results checked by a done-driven scoreboard.
module tb_alu_mdu;
  import alu_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  alu_ctrl = '0;
  logic [31:0] a = '0, b = '0;
  logic        start = 1'b0;
  logic [31:0] c, hi, lo;
  logic        zero, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  alu_mdu #(.WIDTH(32), .SHW(5), .CTRL_W(6)) dut (
    .clk(clk), .rst(rst), .alu_ctrl(alu_ctrl), .a(a), .b(b), .start(start),
    .c(c), .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: hi=%h lo=%h with nothing expected", hi, lo);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (hi !== e.hi || lo !== e.lo) begin
          n_fail++;
          $display("FAIL %s: got hi=%h lo=%h expected hi=%h lo=%h", e.name, hi, lo, e.hi, e.lo);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic comb(input string nm, input logic [5:0] op, input logic [31:0] av,
                      input logic [31:0] bv, input logic [31:0] exp);
    @(negedge clk);
    alu_ctrl = op; a = av; b = bv; start = 1'b0;
    #1;
    chk(nm, c, exp);
  endtask

  // Pulse start across one rising edge, then scramble operands
  task automatic issue(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    alu_ctrl = op; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
    alu_ctrl = OP_AND;
  endtask

  // Returns the cycle (1 = first after the start edge) in which done appears
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0; busy_cnt = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic seq(input string nm, input logic [5:0] op, input logic [31:0] av,
                     input logic [31:0] bv, input logic [31:0] ehi, input logic [31:0] elo,
                     input int exp_lat);
    int lat, bc;
    exp_t e;
    e.name = nm; e.hi = ehi; e.lo = elo;
    sb.push_back(e);
    issue(op, av, bv);
    wait_done(lat, bc);
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_busy_cycles"}, 32'(bc), 32'(exp_lat - 1));
    chk({nm, "_busy_at_done"}, 32'(busy), 32'h0);
  endtask

  initial begin
    int lat, bc;
    exp_t e;

    #12;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    comb("add",     OP_ADD,  32'd5,        32'd7,        32'd12);
    comb("addu_wrap", OP_ADDU, 32'hFFFFFFFF, 32'd2,      32'd1);
    comb("subu",    OP_SUBU, 32'd3,        32'd5,        32'hFFFFFFFE);
    comb("slt",     OP_SLT,  32'hFFFFFFFF, 32'd1,        32'd1);
    comb("sltu",    OP_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0);
    comb("lui",     OP_LUI,  32'd0,        32'h00001234, 32'h12340000);
    comb("nor",     OP_NOR,  32'h0F0F0000, 32'h000000F0, 32'hF0F0FF0F);
    comb("xor",     OP_XOR,  32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0);
    comb("sll",     OP_SLL,  32'd31,       32'd1,        32'h80000000);
    comb("srl",     OP_SRL,  32'd4,        32'h80000000, 32'h08000000);
    comb("sra",     OP_SRA,  32'd36,       32'h80000000, 32'hF8000000);
    comb("seq_code_c0", OP_MULT, 32'd3,    32'd4,        32'd0);
    comb("zero_eq", OP_ADD,  32'hDEADBEEF, 32'hDEADBEEF, 32'hBD5B7DDE);
    chk("zero_flag_eq", 32'(zero), 32'h1);
    comb("zero_ne", OP_ADD,  32'd1,        32'd2,        32'd3);
    chk("zero_flag_ne", 32'(zero), 32'h0);

    seq("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34);
    seq("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd4,        32'hFFFFFFFF, 32'hFFFFFFF4, 34);
    seq("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 34);
    seq("divu",      OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       34);
    seq("div_by0",   OP_DIV,   32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 2);
    seq("div_min",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 34);

    // mthi during a running mult must be ignored
    e.name = "mult_mthi_busy"; e.hi = 32'h0; e.lo = 32'd12;
    sb.push_back(e);
    issue(OP_MULT, 32'd3, 32'd4);
    repeat (3) @(negedge clk);
    alu_ctrl = OP_MTHI; a = 32'hAA; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc);
    chk("mult_mthi_done_seen", 32'(lat > 0), 32'h1);

    @(negedge clk);
    alu_ctrl = OP_MTHI; a = 32'hAA; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("mthi_idle", hi, 32'hAA);
    comb("mfhi", OP_MFHI, 32'd0, 32'd0, 32'hAA);
    @(negedge clk);
    alu_ctrl = OP_MTLO; a = 32'h55; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    comb("mflo", OP_MFLO, 32'd0, 32'd0, 32'h55);

    // Reset in cycle 10 of a mult aborts it with no done pulse
    issue(OP_MULT, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seq("mult_after_rst", OP_MULT, 32'd6, 32'd7, 32'h0, 32'd42, 34);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
